// File: rtl/accum_adder_tree_if.sv
// Beat-in / result-out stream bundle for the accumulating adder tree.
// slave = the tree itself, master = whoever feeds beats and drains results.
interface accum_adder_tree_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 8,
  parameter int ACC_WIDTH  = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic                         in_last;
  logic                         in_mode;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_WIDTH-1:0]         out_data;
  logic                         out_ovf;

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/accum_adder_tree.sv
// Pipelined signed lane-reduction tree with optional multi-beat accumulation.
// One register stage per tree layer; a held output freezes every stage (global stall).

module accum_adder_tree_node #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         adv,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  always_ff @(posedge clk)
    if (adv) s <= a + b;
endmodule

module accum_adder_tree #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 8,
  parameter int ACC_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst,
  accum_adder_tree_if.slave bus
);
  localparam int LAYERS = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
  localparam int NPAD   = 1 << LAYERS;
  localparam int NNODE  = 2*NPAD - 1;

  if (ACC_WIDTH < DATA_WIDTH + LAYERS) begin : g_bad_width
    $error("accum_adder_tree: ACC_WIDTH too narrow for DATA_WIDTH and NUM_IN");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  logic                           adv, fire, add_ovf;
  logic [LAYERS:0]                vld_pipe, lst_pipe, mod_pipe;
  logic [NPAD*DATA_WIDTH-1:0]     din_pad;
  logic [NPAD-1:0][ACC_WIDTH-1:0] leaf;
  logic [NNODE-1:0][ACC_WIDTH-1:0] tr;
  logic signed [ACC_WIDTH-1:0]    sum, add, acc, acc_nx, out_d, out_d_nx;
  logic                           ovf, ovf_nx, out_o, out_o_nx, out_v, out_v_nx;
  state_t                         state, state_nx;

  assign adv          = !(out_v && !bus.out_ready);
  assign bus.in_ready = adv && !rst;
  assign din_pad      = (NPAD*DATA_WIDTH)'(bus.in_data);

  // Sideband travels with the data; no bubble collapse, every stage moves on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      mod_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= bus.in_valid;
      lst_pipe[0] <= bus.in_last;
      mod_pipe[0] <= bus.in_mode;
      for (int i = 1; i <= LAYERS; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
        mod_pipe[i] <= mod_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk)
    if (adv)
      for (int j = 0; j < NPAD; j++)
        leaf[j] <= (j < NUM_IN) ? ACC_WIDTH'($signed(din_pad[j*DATA_WIDTH +: DATA_WIDTH])) : '0;

  // Heap layout: node h (1-based) lives at tr[h-1], children at heap 2h and 2h+1.
  assign tr[NNODE-1:NPAD-1] = leaf;

  for (genvar h = 1; h < NPAD; h++) begin : g_node
    accum_adder_tree_node #(.W(ACC_WIDTH)) u_node (
      .clk (clk),
      .adv (adv),
      .a   (tr[2*h-1]),
      .b   (tr[2*h]),
      .s   (tr[h-1])
    );
  end

  assign sum     = tr[0];
  assign fire    = adv && vld_pipe[LAYERS];
  assign add     = acc + sum;
  assign add_ovf = (acc[ACC_WIDTH-1] == sum[ACC_WIDTH-1]) && (add[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      out_d <= '0;
      out_o <= 1'b0;
      out_v <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      ovf   <= ovf_nx;
      out_d <= out_d_nx;
      out_o <= out_o_nx;
      out_v <= out_v_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf;
    out_d_nx = out_d;
    out_o_nx = out_o;
    out_v_nx = out_v && !bus.out_ready;
    if (fire) begin
      unique case (state)
        IDLE: begin
          if (!mod_pipe[LAYERS] || lst_pipe[LAYERS]) begin
            out_d_nx = sum;
            out_o_nx = 1'b0;
            out_v_nx = 1'b1;
          end else begin
            acc_nx   = sum;
            ovf_nx   = 1'b0;
            state_nx = ACCUM;
          end
        end
        ACCUM: begin
          // Once a group is open its beats accumulate regardless of their own mode bit.
          if (lst_pipe[LAYERS]) begin
            out_d_nx = add;
            out_o_nx = ovf | add_ovf;
            out_v_nx = 1'b1;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            state_nx = IDLE;
          end else begin
            acc_nx = add;
            ovf_nx = ovf | add_ovf;
          end
        end
      endcase
    end
  end

  assign bus.out_valid = out_v;
  assign bus.out_data  = out_d;
  assign bus.out_ovf   = out_o;
endmodule
